// File: rtl/sys_defs.sv
// Shared processor types: the execute-to-complete packet, the CDB broadcast tag,
// the complete-to-ROB packet, and the default complete-stage FIFO depth.
`ifndef IC_DEPTH
`define IC_DEPTH 4
`endif

package sys_defs;

    localparam int XLEN             = 32;
    localparam int PHYS_REG_W       = 6;
    localparam int ROB_IDX_W        = 5;
    localparam int IC_DEPTH_DEFAULT = `IC_DEPTH;

    typedef struct packed {
        logic                  valid;
        logic [PHYS_REG_W-1:0] phys_reg;
    } CDB_PACKET;

    typedef struct packed {
        logic [XLEN-1:0]      result;
        logic [XLEN-1:0]      NPC;
        logic                 take_branch;
        logic [XLEN-1:0]      rs2_value;
        logic                 wr_mem;
        CDB_PACKET            dest_tag;
        logic                 halt;
        logic                 illegal;
        logic                 csr_op;
        logic [ROB_IDX_W-1:0] rob_idx;
    } EX_IC_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 take_branch;
        logic [XLEN-1:0]      target;
        logic                 halt;
        logic                 illegal;
        logic                 wr_mem;
        logic                 csr_op;
        logic [XLEN-1:0]      st_addr;
        logic [XLEN-1:0]      st_data;
    } IC_ROB_PACKET;

endpackage

// File: rtl/stage_ic_fifo.sv
// Circular in-order FIFO of execute results with flush; exposes the head entry
// and the registered occupancy.
module ic_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = IC_DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  EX_IC_PACKET      i_din,
    output EX_IC_PACKET      o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    EX_IC_PACKET      r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Guard locally so the FIFO never over/underflows regardless of the caller.
    assign w_push = i_push && !i_flush && (r_count != CNT_W'(DEPTH));
    assign w_pop  = i_pop  && !i_flush && (r_count != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // NOTE: payload storage has no reset; validity comes solely from r_count,
    // so clearing the array would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_tail] <= i_din;
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/stage_ic.sv
// Complete stage: queues execute results, requests CDB wakeup broadcasts for
// entries with a real destination, and retires every entry to the ROB in order.
module stage_ic
    import sys_defs::*;
#(
    parameter int IC_DEPTH = IC_DEPTH_DEFAULT,
    parameter int CNT_W    = $clog2(IC_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ex_ic_valid,
    input  EX_IC_PACKET      ex_ic_packet,
    output logic             ic_ex_ready,
    input  logic             flush,
    input  logic             cdb_grant,
    output logic             cdb_request,
    output CDB_PACKET        cdb_packet,
    output IC_ROB_PACKET     ic_rob_packet,
    output logic [CNT_W-1:0] ic_count
);

    EX_IC_PACKET      w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_nonempty;
    logic             w_needs_cdb;
    logic             w_push;
    logic             w_pop;
    logic             w_unused_npc;

    ic_fifo #(
        .DEPTH (IC_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_din   (ex_ic_packet),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Ready looks only at the registered count, keeping the grant path out of
    // the execute back-pressure timing.
    assign ic_ex_ready = (w_count != CNT_W'(IC_DEPTH));
    assign w_nonempty  = (w_count != '0);

    // Stores, x0 writes and illegal instructions have nothing to wake up.
    assign w_needs_cdb = w_head.dest_tag.valid
                      && (w_head.dest_tag.phys_reg != '0)
                      && !w_head.illegal;

    assign w_push      = ex_ic_valid && ic_ex_ready && !flush;
    assign w_pop       = w_nonempty && !flush && (w_needs_cdb ? cdb_grant : 1'b1);
    assign cdb_request = w_nonempty && w_needs_cdb && !flush;
    assign ic_count    = w_count;

    // The ROB rebuilds the fall-through PC itself, so NPC is carried but unused.
    assign w_unused_npc = ^w_head.NPC;

    // NOTE: every output struct gets a full default first so no field can
    // hold its previous value and infer a latch.
    always_comb begin
        cdb_packet          = '0;
        cdb_packet.valid    = w_pop && w_needs_cdb;
        cdb_packet.phys_reg = w_head.dest_tag.phys_reg;

        ic_rob_packet             = '0;
        ic_rob_packet.valid       = w_pop;
        ic_rob_packet.rob_idx     = w_head.rob_idx;
        ic_rob_packet.take_branch = w_head.take_branch;
        ic_rob_packet.target      = w_head.result;
        ic_rob_packet.halt        = w_head.halt;
        ic_rob_packet.illegal     = w_head.illegal;
        ic_rob_packet.wr_mem      = w_head.wr_mem;
        ic_rob_packet.csr_op      = w_head.csr_op;
        ic_rob_packet.st_addr     = w_head.result;
        ic_rob_packet.st_data     = w_head.rs2_value;
    end

endmodule

// File: doc/stage_ic.md
Name: stage_ic

Overview:
- Complete stage directly downstream of the execute stage.
- Buffers completed execute results in a small in-order FIFO.
- Requests the shared CDB to broadcast each result's physical destination tag (wakeup).
- Signals completion to the ROB with branch and store information.
- Back-pressures execute when full; squashes all contents on a mispredict flush.

Parameters:
- IC_DEPTH, 4, number of FIFO entries (power of two, at least 2).
- CNT_W, $clog2(IC_DEPTH+1), width of the occupancy count.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  reset; asynchronous, active-low
- ex_ic_valid  in  1  ex_ic_packet holds a valid completed instruction
- ex_ic_packet  in  EX_IC_PACKET  result, NPC, take_branch, rs2_value, wr_mem, dest_tag, halt, illegal, csr_op, rob_idx
- ic_ex_ready  out  1  stage can accept a packet this cycle
- flush  in  1  mispredict recovery; squash all entries
- cdb_grant  in  1  CDB arbiter grants this stage the bus this cycle
- cdb_request  out  1  head entry needs a CDB broadcast
- cdb_packet  out  CDB_PACKET  {valid, phys_reg} broadcast tag
- ic_rob_packet  out  IC_ROB_PACKET  {valid, rob_idx, take_branch, target, halt, illegal, wr_mem, csr_op, st_addr, st_data}
- ic_count  out  CNT_W  current occupancy

Behaviour:
- State: circular FIFO of IC_DEPTH EX_IC_PACKET entries, head/tail pointers, count register.
- Reset (reset==0, async): head=tail=0, count=0; all outputs derived from an empty FIFO. ic_ex_ready=1, cdb_request=0, cdb_packet.valid=0, ic_rob_packet.valid=0, ic_count=0. Entry payloads need not be cleared.
- Push = ex_ic_valid && ic_ex_ready && !flush. Payload is written at tail on the rising edge; tail advances modulo IC_DEPTH.
- ic_ex_ready = (count != IC_DEPTH). It depends on registered count only; no combinational dependence on pop or cdb_grant.
- needs_cdb(head) = dest_tag.valid && dest_tag.phys_reg != 0 && !illegal.
- cdb_request = (count != 0) && needs_cdb(head) && !flush.
- Pop = (count != 0) && !flush && (needs_cdb(head) ? cdb_grant : 1). Entries with no destination (stores, x0 writes, illegal) retire to the ROB without the bus. A grant while cdb_request=0 is ignored.
- Output timing: cdb_packet and ic_rob_packet are combinational from the head entry and are valid only in the pop cycle.
  - cdb_packet.valid = pop && needs_cdb(head); phys_reg = head dest_tag.phys_reg.
  - ic_rob_packet.valid = pop; target = head result; st_addr = head result; st_data = head rs2_value; other fields copied from head.
- Latency: a packet pushed at edge t can be popped in the cycle after t. Minimum EX-to-CDB latency is one cycle; no same-cycle bypass.
- Count next state is count + push - pop. Simultaneous push and pop leaves count unchanged; legal at any occupancy below full.
- Full: ic_ex_ready=0 and no push. The pop in that cycle frees a slot, visible the next cycle.
- Empty: no pop; all valids 0; a push in the same cycle is not visible until the next cycle.
- Wrap-around: pointers wrap modulo IC_DEPTH; FIFO order is preserved across the wrap.
- Flush: in that cycle all output valids and cdb_request are forced to 0 and the push is dropped. At the edge, head=tail=count=0. Flush with reset low: reset dominates.
- Reset mid-operation clears immediately, without waiting for a clock edge; partially queued results are discarded.

Decomposition:
- Package additions (sys_defs):
  - CDB_PACKET typedef {valid, phys_reg}.
  - IC_ROB_PACKET typedef.
  - `IC_DEPTH default.
  - EX_IC_PACKET stays in the package unchanged.
- Natural sub-module: ic_fifo, a generic synchronous FIFO of EX_IC_PACKET with push, pop, flush, count, and head outputs. stage_ic wraps it with the needs_cdb, pop, and output logic.

Test Plan:
- Reset, then push 3 packets: tags p5/p6/p7, rob_idx 1/2/3, cdb_grant=1 always. Expect cdb tags 5, 6, 7 on consecutive cycles starting one cycle after the first push; ic_rob rob_idx 1, 2, 3; ic_count peaks at 1.
- cdb_grant=0, push 4 packets. Expect ic_count=4 and ic_ex_ready=0; a 5th packet is held. Raise grant: one pop per cycle; ready returns the cycle after the first pop; the 5th packet completes last, in order.
- Head is a store (wr_mem=1, dest_tag.valid=0, result=0x1000, rs2_value=0xAB), cdb_grant=0. Expect the ROB packet with st_addr=0x1000, st_data=0xAB and cdb_packet.valid=0 in the cycle after the push; cdb_request stays 0.
- Fill 3 entries, assert flush with a simultaneous push. That cycle: all valids 0. Next cycle: ic_count=0, ic_ex_ready=1, and the flushed/pushed packets never appear.
- Run 10 push/pop pairs with IC_DEPTH=4 to force pointer wrap. Expect rob_idx order 0 to 9 with no loss or duplication.
- Drop reset low mid-cycle with 2 entries queued. Outputs go invalid and ic_count=0 immediately, before the next clock edge.
